// File: rtl/mgt01_booth_mul_seq_pkg.sv
// Shared types for the iterative radix-4 Booth multiplier: operation codes,
// functional-unit occupancy and the multiplier FSM states.
package mgt01_booth_mul_seq_pkg;

  typedef enum logic [1:0] {
    MUL_    = 2'd0,
    MULH_   = 2'd1,
    MULHSU_ = 2'd2,
    MULHU_  = 2'd3
  } mul_ops_e;

  // FU_BUSY rather than BUSY so it does not collide with the FSM literal below.
  typedef enum logic {
    FREE    = 1'b0,
    FU_BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_fsm_e;

endpackage

// File: rtl/mgt01_booth_r4_digit.sv
// Radix-4 Booth digit decode: {A[1:0],L} selects 0, +-M or +-2M, returned
// sign-extended to the accumulator width.
module mgt01_booth_r4_digit #(
  parameter int XLEN = 32
) (
  input  logic [2:0]      sel_i,
  input  logic [XLEN+1:0] mcand_i,
  output logic [XLEN+3:0] addend_o
);

  logic signed [XLEN+3:0] m_1x;
  logic signed [XLEN+3:0] m_2x;

  assign m_1x = {{2{mcand_i[XLEN+1]}}, mcand_i};
  assign m_2x = {mcand_i[XLEN+1], mcand_i, 1'b0};

  always_comb begin
    addend_o = '0;
    case (sel_i)
      3'b001, 3'b010: addend_o = m_1x;
      3'b011:         addend_o = m_2x;
      3'b100:         addend_o = -m_2x;
      3'b101, 3'b110: addend_o = -m_1x;
      default:        addend_o = '0;
    endcase
  end

endmodule

// File: rtl/mgt01_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHSU/MULHU), ITER = XLEN/2+1 steps.
// Optional result cache of the last operand pair: define MGT01_MUL_RESULT_CACHE_EN.
module mgt01_booth_mul_seq
  import mgt01_booth_mul_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clk_en_i,
  input  logic            kill_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] multiplicand_i,
  input  logic [XLEN-1:0] multiplier_i,
  input  mul_ops_e        operation_i,
  output logic [XLEN-1:0] result_o,
  output logic            valid_o,
  output fu_state_e       fu_state_o,
  output mul_fsm_e        dbg_state_o
);

  localparam int ITER = XLEN / 2 + 1;
  localparam int CW   = $clog2(ITER);
  localparam int EW   = XLEN + 2;
  localparam int PW   = XLEN + 4;
  localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

  function automatic logic [XLEN-1:0] pick_half(input logic [2*XLEN-1:0] prod,
                                                input mul_ops_e op);
    return (op == MUL_) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // Handshake: a request transfers on a clock edge where valid_i & ready_o &
  // clk_en_i & ~kill_i; valid_o is a single-cycle pulse (held only while clk_en_i=0).
  mul_fsm_e        state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            accept;
  logic            last_step;
  logic            cache_hit;
  logic [2*XLEN-1:0] cache_prod;

  logic                 mcand_signed, mplier_signed;
  logic [EW-1:0]        mcand_ext, mplier_ext;
  logic signed [PW-1:0] p_q, addend, p_sum, p_next;
  logic [EW-1:0]        a_q, a_next, m_q;
  logic                 l_q;
  mul_ops_e             op_q;
  logic [2*XLEN-1:0]    prod_next;
  logic [XLEN-1:0]      result_q;

  assign mcand_signed  = (operation_i != MULHU_);
  assign mplier_signed = (operation_i == MUL_) || (operation_i == MULH_);
  assign mcand_ext  = {{2{mcand_signed & multiplicand_i[XLEN-1]}}, multiplicand_i};
  assign mplier_ext = {{2{mplier_signed & multiplier_i[XLEN-1]}}, multiplier_i};

  assign ready_o     = (state_q == IDLE) || (state_q == DONE);
  assign valid_o     = (state_q == DONE);
  assign fu_state_o  = ready_o ? FREE : FU_BUSY;
  assign result_o    = result_q;
  assign dbg_state_o = state_q;

  assign accept    = valid_i & ready_o & clk_en_i & ~kill_i;
  assign last_step = (cnt_q == LAST_CNT);

  mgt01_booth_r4_digit #(.XLEN(XLEN)) u_digit (
    .sel_i    ({a_q[1:0], l_q}),
    .mcand_i  (m_q),
    .addend_o (addend)
  );

  // One step: add the digit, then shift {P,A,L} right by two arithmetically.
  assign p_sum     = p_q + addend;
  assign p_next    = p_sum >>> 2;
  assign a_next    = {p_sum[1:0], a_q[EW-1:2]};
  assign prod_next = {p_next[XLEN-3:0], a_next};

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = cache_hit ? DONE : BUSY;
        BUSY:    if (last_step) state_d = DONE;
        DONE:    state_d = accept ? (cache_hit ? DONE : BUSY) : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else if (clk_en_i) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_q      <= '0;
      a_q      <= '0;
      l_q      <= 1'b0;
      m_q      <= '0;
      op_q     <= MUL_;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (clk_en_i) begin
      if (kill_i) begin
        cnt_q <= '0;
      end else if (accept) begin
        p_q   <= '0;
        a_q   <= mplier_ext;
        l_q   <= 1'b0;
        m_q   <= mcand_ext;
        op_q  <= operation_i;
        cnt_q <= '0;
        if (cache_hit) result_q <= pick_half(cache_prod, operation_i);
      end else if (state_q == BUSY) begin
        p_q   <= p_next;
        a_q   <= a_next;
        l_q   <= a_q[1];
        cnt_q <= last_step ? '0 : cnt_q + CW'(1);
        if (last_step) result_q <= pick_half(prod_next, op_q);
      end
    end
  end

`ifdef MGT01_MUL_RESULT_CACHE_EN
  // Keyed on the extended operands so MULH followed by MUL on the same registers hits.
  logic              c_valid_q;
  logic [EW-1:0]     c_mcand_q, c_mplier_q, mplier_q;
  logic [2*XLEN-1:0] c_prod_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      c_valid_q  <= 1'b0;
      c_mcand_q  <= '0;
      c_mplier_q <= '0;
      mplier_q   <= '0;
      c_prod_q   <= '0;
    end else if (clk_en_i) begin
      if (kill_i) begin
        c_valid_q <= 1'b0;
      end else begin
        if (accept) mplier_q <= mplier_ext;
        if ((state_q == BUSY) && last_step) begin
          c_valid_q  <= 1'b1;
          c_mcand_q  <= m_q;
          c_mplier_q <= mplier_q;
          c_prod_q   <= prod_next;
        end
      end
    end
  end

  assign cache_hit  = c_valid_q && (c_mcand_q == mcand_ext) && (c_mplier_q == mplier_ext);
  assign cache_prod = c_prod_q;
`else
  assign cache_hit  = 1'b0;
  assign cache_prod = '0;
`endif

endmodule

// File: tb/tb_mgt01_booth_mul_seq.sv
// Self-checking bench for mgt01_booth_mul_seq (XLEN=32) against a wide-integer
// product model; honours MGT01_MUL_RESULT_CACHE_EN for expected latencies.
module tb_mgt01_booth_mul_seq;
  import mgt01_booth_mul_seq_pkg::*;

  localparam int XLEN = 32;
  localparam int ITER = XLEN / 2 + 1;
  localparam int LAT  = ITER + 1;
  localparam int TMO  = 200;
  localparam int NRND = 1500;
  localparam int NB2B = 8;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, clk_en, kill, valid_i;
  logic [XLEN-1:0] a_i, b_i;
  mul_ops_e op_i;
  logic ready, valid_o;
  logic [XLEN-1:0] result;
  fu_state_e fu;
  mul_fsm_e dbg;

  always #5 clk = ~clk;

  mgt01_booth_mul_seq #(.XLEN(XLEN)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_en_i       (clk_en),
    .kill_i         (kill),
    .valid_i        (valid_i),
    .ready_o        (ready),
    .multiplicand_i (a_i),
    .multiplier_i   (b_i),
    .operation_i    (op_i),
    .result_o       (result),
    .valid_o        (valid_o),
    .fu_state_o     (fu),
    .dbg_state_o    (dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] last_res = '0;
  logic [67:0] c_key = '0;
  bit c_valid = 1'b0;
  logic [XLEN-1:0] exp_q[$];
  int lat_q[$];

  // ---------------- reference model ----------------
  function automatic logic signed [65:0] ext66(input logic [31:0] v, input bit sgn);
    logic signed [65:0] r;
    r = {{34{sgn & v[31]}}, v};
    return r;
  endfunction

  function automatic logic [31:0] ref_mul(input mul_ops_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = ext66(a, op != MULHU_);
    sb = ext66(b, (op == MUL_) || (op == MULH_));
    p  = sa * sb;
    return (op == MUL_) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [67:0] key_of(input mul_ops_e op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [65:0] sa, sb;
    sa = ext66(a, op != MULHU_);
    sb = ext66(b, (op == MUL_) || (op == MULH_));
    return {sa[33:0], sb[33:0]};
  endfunction

  function automatic int exp_lat(input mul_ops_e op, input logic [31:0] a,
                                 input logic [31:0] b);
`ifdef MGT01_MUL_RESULT_CACHE_EN
    if (c_valid && (c_key == key_of(op, a, b))) return 1;
`endif
    return LAT;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic note_done(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b);
    c_key   = key_of(op, a, b);
    c_valid = 1'b1;
  endtask

  // Issue one op from a negedge with ready_o high; lat counts negedges after the
  // accepting edge until valid_o is seen. Optional clk_en_i stall window.
  task automatic run_op(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b,
                        input int stall_at, input int stall_len,
                        output logic [31:0] res, output int lat, output int busy,
                        output bit pulse_ok);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1; busy = 0;
    while (valid_o !== 1'b1 && lat < TMO) begin
      if (ready !== 1'b1) busy++;
      if (lat == stall_at) clk_en = 1'b0;
      if (lat == stall_at + stall_len) clk_en = 1'b1;
      @(negedge clk);
      lat++;
    end
    clk_en = 1'b1;
    res = result;
    @(negedge clk);
    pulse_ok = (valid_o === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; kill = 1'b0; valid_i = 1'b0;
    op_i = MUL_; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    checks++; if (fu !== FREE) begin errors++; $display("FAIL reset_fu got %0d exp FREE", fu); end
    checks++; if (dbg !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg); end
  endtask

  task automatic test_directed();
    mul_ops_e    ops[6] = '{MUL_, MULHU_, MULH_, MULHSU_, MULH_, MUL_};
    logic [31:0] av[6]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h8000_0000};
    logic [31:0] bv[6]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'h8000_0000, 32'h8000_0000};
    logic [31:0] ev[6]  = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                            32'h4000_0000, 32'h0};
    logic [31:0] res;
    int lat, busy, el;
    bit pok;
    for (int i = 0; i < 6; i++) begin
      el = exp_lat(ops[i], av[i], bv[i]);
      run_op(ops[i], av[i], bv[i], 0, 0, res, lat, busy, pok);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL dir_res[%0d] got %h exp %h", i, res, ev[i]); end
      checks++; if (lat !== el) begin errors++; $display("FAIL dir_lat[%0d] got %0d exp %0d", i, lat, el); end
      checks++; if (busy !== el - 1) begin errors++; $display("FAIL dir_busy[%0d] got %0d exp %0d", i, busy, el - 1); end
      checks++; if (!pok) begin errors++; $display("FAIL dir_pulse[%0d] got valid_o high exp low", i); end
      note_done(ops[i], av[i], bv[i]);
      last_res = ev[i];
    end
  endtask

  task automatic test_kill();
    logic [31:0] a, b, res, exp;
    mul_ops_e op;
    int lat, busy, n, seen;
    bit pok;
    op = MULHU_;
    do begin a = $urandom; b = $urandom; end while (exp_lat(op, a, b) != LAT);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; n = 1;
    while (n < 5) begin
      if (n == 3) begin
        checks++; if (fu !== FU_BUSY) begin errors++; $display("FAIL kill_fu_busy got %0d exp FU_BUSY", fu); end
        checks++; if (dbg !== BUSY) begin errors++; $display("FAIL kill_state_busy got %0d exp BUSY", dbg); end
      end
      @(negedge clk); n++;
    end
    kill = 1'b1; valid_i = 1'b1; a_i = ~a; op_i = MUL_;
    @(negedge clk);
    kill = 1'b0; valid_i = 1'b0;
    c_valid = 1'b0;
    seen = 0;
    repeat (30) begin
      if (valid_o === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL kill_no_valid got %0d pulses exp 0", seen); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL kill_ready got %b exp 1", ready); end
    checks++; if (result !== last_res) begin errors++; $display("FAIL kill_result_hold got %h exp %h", result, last_res); end
    exp = ref_mul(op, a, b);
    run_op(op, a, b, 0, 0, res, lat, busy, pok);
    checks++; if (res !== exp) begin errors++; $display("FAIL kill_next_res got %h exp %h", res, exp); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL kill_next_lat got %0d exp %0d", lat, LAT); end
    note_done(op, a, b);
    last_res = exp;
  endtask

  task automatic test_async_reset();
    logic [31:0] a, b, res, exp;
    mul_ops_e op;
    int lat, busy, seen, el;
    bit pok;
    op = MULH_;
    do begin a = $urandom; b = $urandom; end while (exp_lat(op, a, b) != LAT);
    op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", valid_o); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL arst_result got %h exp 0", result); end
    checks++; if (fu !== FREE) begin errors++; $display("FAIL arst_fu got %0d exp FREE", fu); end
    #1 rst = 1'b0;
    c_valid = 1'b0; last_res = '0;
    @(negedge clk);
    seen = 0;
    repeat (25) begin
      if (valid_o === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL arst_dropped got %0d pulses exp 0", seen); end
    op = MULHSU_; a = $urandom; b = $urandom;
    exp = ref_mul(op, a, b); el = exp_lat(op, a, b);
    run_op(op, a, b, 0, 0, res, lat, busy, pok);
    checks++; if (res !== exp) begin errors++; $display("FAIL arst_next_res got %h exp %h", res, exp); end
    checks++; if (lat !== el) begin errors++; $display("FAIL arst_next_lat got %0d exp %0d", lat, el); end
    note_done(op, a, b);
    last_res = exp;
  endtask

  task automatic test_stall();
    logic [31:0] a, b, res, exp;
    mul_ops_e op;
    int lat, busy;
    bit pok;
    op = MUL_;
    do begin a = $urandom; b = $urandom; end while (exp_lat(op, a, b) != LAT);
    exp = ref_mul(op, a, b);
    run_op(op, a, b, 5, 3, res, lat, busy, pok);
    checks++; if (res !== exp) begin errors++; $display("FAIL stall_res got %h exp %h", res, exp); end
    checks++; if (lat !== LAT + 3) begin errors++; $display("FAIL stall_lat got %0d exp %0d", lat, LAT + 3); end
    checks++; if (!pok) begin errors++; $display("FAIL stall_pulse got valid_o high exp low"); end
    note_done(op, a, b);
    last_res = exp;
  endtask

  task automatic test_back_to_back();
    mul_ops_e ops[NB2B];
    logic [31:0] av[NB2B], bv[NB2B];
    mul_ops_e done_op[$];
    logic [31:0] done_a[$], done_b[$];
    logic [31:0] e;
    int issued, done, n, guard, el;
    for (int i = 0; i < NB2B; i++) begin
      ops[i] = mul_ops_e'($urandom_range(0, 3));
      av[i] = pick_val(); bv[i] = pick_val();
    end
    op_i = ops[0]; a_i = av[0]; b_i = bv[0]; valid_i = 1'b1;
    exp_q.push_back(ref_mul(ops[0], av[0], bv[0]));
    lat_q.push_back(exp_lat(ops[0], av[0], bv[0]));
    done_op.push_back(ops[0]); done_a.push_back(av[0]); done_b.push_back(bv[0]);
    issued = 1; done = 0; guard = 0;
    @(negedge clk);
    valid_i = 1'b0; n = 1;
    while (done < NB2B && guard < 1000) begin
      if (valid_o === 1'b1) begin
        e = exp_q.pop_front();
        el = lat_q.pop_front();
        checks++; if (result !== e) begin errors++; $display("FAIL b2b_res[%0d] got %h exp %h", done, result, e); end
        checks++; if (n !== el) begin errors++; $display("FAIL b2b_lat[%0d] got %0d exp %0d", done, n, el); end
        note_done(done_op.pop_front(), done_a.pop_front(), done_b.pop_front());
        last_res = e;
        done++;
        if (issued < NB2B) begin
          op_i = ops[issued]; a_i = av[issued]; b_i = bv[issued]; valid_i = 1'b1;
          exp_q.push_back(ref_mul(ops[issued], av[issued], bv[issued]));
          lat_q.push_back(exp_lat(ops[issued], av[issued], bv[issued]));
          done_op.push_back(ops[issued]); done_a.push_back(av[issued]); done_b.push_back(bv[issued]);
          issued++;
          n = 0;
        end
      end
      @(negedge clk);
      valid_i = 1'b0; n++; guard++;
    end
    checks++; if (done !== NB2B) begin errors++; $display("FAIL b2b_timeout got %0d results exp %0d", done, NB2B); end
    exp_q.delete(); lat_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    mul_ops_e op;
    int lat, busy, el;
    bit pok;
    a = pick_val(); b = pick_val();
    for (int i = 0; i < NRND; i++) begin
      op = mul_ops_e'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin a = pick_val(); b = pick_val(); end
      exp = ref_mul(op, a, b);
      el = exp_lat(op, a, b);
      run_op(op, a, b, 0, 0, res, lat, busy, pok);
      checks++; if (res !== exp) begin errors++; $display("FAIL rnd_res[%0d] op %0d a %h b %h got %h exp %h", i, op, a, b, res, exp); end
      checks++; if (lat !== el) begin errors++; $display("FAIL rnd_lat[%0d] got %0d exp %0d", i, lat, el); end
      note_done(op, a, b);
      last_res = exp;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_kill();
    test_async_reset();
    test_stall();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
